// File: rtl/uncache_unit_pkg.sv
// Shared definitions for the uncached access path: FSM state encodings and
// bus transfer size codes.
package uncache_unit_pkg;

  typedef enum logic [1:0] {
    UC_IDLE = 2'd0,
    UC_REQ  = 2'd1,
    UC_WAIT = 2'd2,
    UC_DONE = 2'd3
  } uc_state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/uncache_unit_strb2size.sv
// Combinational mapping from byte write strobes to a bus transfer size code.
module uncache_unit_strb2size
  import uncache_unit_pkg::*;
#(
  parameter int STRB_W = 4
) (
  input  logic [STRB_W-1:0] i_strb,
  output logic [1:0]        o_size
);

  localparam logic [STRB_W-1:0] STRB_FULL    = '1;
  localparam logic [STRB_W-1:0] STRB_HALF_LO = STRB_FULL >> (STRB_W / 2);
  localparam logic [STRB_W-1:0] STRB_HALF_HI = ~STRB_HALF_LO;

  // Irregular strobe patterns fall back to a full-word transfer.
  always_comb begin
    o_size = SIZE_W;
    if (i_strb == STRB_FULL) begin
      o_size = SIZE_W;
    end else if ((i_strb == STRB_HALF_LO) || (i_strb == STRB_HALF_HI)) begin
      o_size = SIZE_H;
    end else if ($onehot(i_strb)) begin
      o_size = SIZE_B;
    end
  end

endmodule

// File: rtl/uncache_unit.sv
// Services non-cacheable (kseg1) CPU data accesses as single-beat transactions
// on an SRAM-like bus, stalling the pipeline until each one completes.
module uncache_unit
  import uncache_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    cpu_en,
  input  logic                    cpu_cache_v,
  input  logic [DATA_WIDTH/8-1:0] cpu_wen,
  input  logic [1:0]              cpu_size,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata,
  output logic                    stallreq,
  output logic [DATA_WIDTH-1:0]   cpu_rdata,
  output logic                    mem_req,
  output logic                    mem_wr,
  output logic [1:0]              mem_size,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_addr_ok,
  input  logic                    mem_data_ok,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int STRB_W = DATA_WIDTH / 8;

  uc_state_e             r_state;
  uc_state_e             w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [STRB_W-1:0]     r_wen;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [1:0]            r_size;
  logic                  r_wr;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_uc;
  logic                  w_is_wr;
  logic [1:0]            w_wr_size;
  logic                  w_capture;

  assign w_uc    = cpu_en & ~cpu_cache_v;
  assign w_is_wr = |cpu_wen;

  uncache_unit_strb2size #(
    .STRB_W (STRB_W)
  ) u_strb2size (
    .i_strb (cpu_wen),
    .o_size (w_wr_size)
  );

  // DONE never looks at cpu_en: the CPU is still presenting the request that
  // just completed, and re-issuing it would duplicate the access.
  always_comb begin
    w_state_next = r_state;
    stallreq     = 1'b0;
    w_capture    = 1'b0;
    unique case (r_state)
      UC_IDLE: begin
        stallreq = w_uc;
        if (w_uc) w_state_next = UC_REQ;
      end
      UC_REQ: begin
        stallreq = 1'b1;
        if (mem_addr_ok) begin
          if (mem_data_ok) begin
            w_state_next = UC_DONE;
            w_capture    = ~r_wr;
          end else begin
            w_state_next = UC_WAIT;
          end
        end
      end
      UC_WAIT: begin
        stallreq = 1'b1;
        if (mem_data_ok) begin
          w_state_next = UC_DONE;
          w_capture    = ~r_wr;
        end
      end
      UC_DONE: begin
        stallreq     = 1'b0;
        w_state_next = UC_IDLE;
      end
      default: w_state_next = UC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= UC_IDLE;
      r_addr  <= '0;
      r_wen   <= '0;
      r_wdata <= '0;
      r_size  <= '0;
      r_wr    <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == UC_IDLE) && w_uc) begin
        r_addr  <= cpu_addr;
        r_wen   <= cpu_wen;
        r_wdata <= cpu_wdata;
        r_wr    <= w_is_wr;
        r_size  <= w_is_wr ? w_wr_size : cpu_size;
      end
      if (w_capture) r_rdata <= mem_rdata;
    end
  end

  assign mem_req   = (r_state == UC_REQ);
  assign mem_wr    = r_wr;
  assign mem_size  = r_size;
  assign mem_addr  = r_addr;
  assign mem_wstrb = r_wen;
  assign mem_wdata = r_wdata;
  assign cpu_rdata = r_rdata;

endmodule

// File: doc/uncache_unit.md
Name: uncache_unit

Overview:
- Downstream consumer of the kseg address translator. It takes the translated physical address and the cacheable flag (cache_v) for each CPU data access.
- Services every access with cache_v=0, i.e. kseg1 (device/MMIO space), as a single-beat transaction on an SRAM-like memory bus. Stalls the pipeline until the transaction completes.
- Cacheable requests (cache_v=1) are ignored here; the cache handles them.

Parameters:
- ADDR_WIDTH, 32, physical address width
- DATA_WIDTH, 32, data bus width; strobe width = DATA_WIDTH/8

Ports:
- clk  in  1  single clock, all logic on rising edge
- resetn  in  1  synchronous active-low reset
- cpu_en  in  1  CPU access valid this cycle
- cpu_cache_v  in  1  cacheable flag from translator; unit acts only when 0
- cpu_wen  in  4  byte write strobes; 0000 = read
- cpu_size  in  2  read size: 0=byte, 1=half, 2=word
- cpu_addr  in  32  translated physical address
- cpu_wdata  in  32  write data
- stallreq  out  1  hold pipeline
- cpu_rdata  out  32  read data, valid in DONE
- mem_req  out  1  bus request
- mem_wr  out  1  1=write
- mem_size  out  2  transfer size
- mem_addr  out  32  bus address
- mem_wstrb  out  4  write strobes
- mem_wdata  out  32  write data
- mem_addr_ok  in  1  request accepted
- mem_data_ok  in  1  response / write ack
- mem_rdata  in  32  read data

Behaviour:
- Reset (resetn=0 at posedge):
  - state=IDLE; mem_req=0; cpu_rdata=0; all latched request fields=0.
  - Reset has priority over every other event.
  - An in-flight bus transaction is abandoned; the memory side shares the same reset.
- Uncached hit: uc = cpu_en & ~cpu_cache_v.
- stallreq is combinational:
  - = uc in IDLE;
  - = 1 in REQ and WAIT;
  - = 0 in DONE.
- IDLE:
  - On uc, latch addr, wen, wdata and size.
  - mem_wr = |cpu_wen.
  - Write size is derived from the strobes: 1111→2; 0011/1100→1; one-hot→0; any other pattern→2.
  - Next state REQ.
- REQ:
  - mem_req=1; latched fields are driven and held stable.
  - On mem_addr_ok & ~mem_data_ok → WAIT.
  - On mem_addr_ok & mem_data_ok in the same cycle → DONE, capturing mem_rdata.
- WAIT:
  - mem_req=0.
  - On mem_data_ok: capture mem_rdata into cpu_rdata (reads only; writes leave cpu_rdata unchanged) → DONE.
- DONE:
  - One cycle; stallreq=0 so the pipeline advances.
  - cpu_en is ignored this cycle so the still-presented request is not re-issued.
  - → IDLE.
- Latency: minimum 3 cycles from uc to DONE (IDLE, REQ, DONE), given addr_ok and data_ok together.
- Only one outstanding transaction at a time. mem_data_ok outside WAIT/REQ is ignored.
- mem_addr is the full latched address; no low-bit masking is applied.
- A cpu_cache_v=1 request in IDLE leaves the state unchanged and stallreq=0.

Decomposition:
- Shared header alongside the existing cache defines:
  - state encodings UC_IDLE, UC_REQ, UC_WAIT, UC_DONE (2-bit);
  - size codes SIZE_B/H/W.
- Optional sub-module strb2size: combinational 4-bit strobe → 2-bit size. Everything else stays inline.

Test Plan:
- Uncached word read: addr 0x1FAF_0000 (translated from 0xBFAF0000), cache_v=0, wen=0, size=2; addr_ok at cycle 2, data_ok at cycle 4 with 0xDEADBEEF → mem_req high for exactly one cycle; stallreq high for cycles 1–4; cpu_rdata=0xDEADBEEF with stallreq=0 at cycle 5.
- Byte write: wen=0100, wdata=0x00AB0000 → mem_wr=1, mem_size=0, mem_wstrb=0100; cpu_rdata unchanged after DONE.
- addr_ok held low for 5 cycles → mem_req stays 1 and mem_addr/mem_wdata stay stable throughout.
- addr_ok and data_ok in the same cycle → REQ goes straight to DONE; total stall 2 cycles.
- Cacheable request (cache_v=1) → no mem_req and stallreq=0. A uncached request issued back-to-back after DONE → exactly two bus transactions, no duplicate.
- resetn=0 asserted while in WAIT → next cycle state=IDLE, mem_req=0, stallreq=0, cpu_rdata=0.
